// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: coefficients, FSM state type and output saturation for cic_comp_fir
package cic_comp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_RND} comp_state_e;
  // Symmetric 16-tap droop compensator; taps sum to exactly 2^17 for unity DC gain.
  localparam logic signed [17:0] COEF [16] = '{
    -18'sd200, 18'sd300, -18'sd800, 18'sd1500, -18'sd2600, 18'sd4200, -18'sd7000, 18'sd70136,
    18'sd70136, -18'sd7000, 18'sd4200, -18'sd2600, 18'sd1500, -18'sd800, 18'sd300, -18'sd200
  };
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: sample stream into and out of the compensation FIR
// master: upstream/readout side (drives din, din_vld, ovr_clr); slave: the filter
interface cic_comp_fir_if #(parameter int DIN_W = 35, parameter int DOUT_W = 24) ();
  logic signed [DIN_W-1:0] din;
  logic din_vld;
  logic ovr_clr;
  logic signed [DOUT_W-1:0] dout;
  logic dout_vld;
  logic busy;
  logic ovr;
  modport master (output din, din_vld, ovr_clr, input dout, dout_vld, busy, ovr);
  modport slave (input din, din_vld, ovr_clr, output dout, dout_vld, busy, ovr);
endinterface

// File: rtl/comp_mac.sv
// comp_mac: registered signed multiply-accumulate with synchronous clear and enable
// ports: clk, rstn (async active-low), clr (zero acc, wins over en), en, a, b, acc
module comp_mac #(
  parameter int A_W = 35,
  parameter int B_W = 18,
  parameter int ACC_W = 57
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [A_W+B_W-1:0] prod;
  assign prod = (A_W+B_W)'(a) * (A_W+B_W)'(b);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimate-by-2 CIC droop-compensation FIR with a single time-multiplexed MAC
// ports: clk, rstn (async active-low), bus (slave: din/din_vld/ovr_clr in, dout/dout_vld/busy/ovr out)
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DIN_W = 35,
  parameter int DOUT_W = 24,
  parameter int COEF_W = 18,
  parameter int NTAP = 16,
  parameter int SHIFT = 17
) (
  input logic clk,
  input logic rstn,
  cic_comp_fir_if.slave bus
);
  localparam int PW = $clog2(NTAP);
  localparam int ACC_W = DIN_W + COEF_W + PW;
  comp_state_e state;
  logic signed [DIN_W-1:0] dline [NTAP];
  logic [PW-1:0] wr_ptr, k, rd_idx;
  logic phase, busy, accept, start, ovr, dout_vld;
  logic signed [DOUT_W-1:0] dout;
  logic signed [ACC_W-1:0] acc, acc_rnd;
  assign busy = state != ST_IDLE;
  assign accept = bus.din_vld && !busy;
  // the accept that wraps phase 1->0 launches a computation
  assign start = accept && phase;
  // wr_ptr already points past the newest sample, so tap k reads wr_ptr-1-k
  assign rd_idx = wr_ptr - PW'(1) - k;
  assign acc_rnd = acc + (ACC_W'(1) <<< (SHIFT - 1));
  assign bus.dout = dout;
  assign bus.dout_vld = dout_vld;
  assign bus.busy = busy;
  assign bus.ovr = ovr;
  comp_mac #(.A_W(DIN_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start),
    .en    (state == ST_MAC),
    .a     (dline[rd_idx]),
    .b     (COEF_W'(COEF[k])),
    .acc   (acc)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_IDLE;
      wr_ptr <= '0;
      phase <= 1'b0;
      k <= '0;
      dout <= '0;
      dout_vld <= 1'b0;
      ovr <= 1'b0;
      for (int i = 0; i < NTAP; i++) dline[i] <= '0;
    end else begin
      dout_vld <= 1'b0;
      ovr <= (bus.din_vld && busy) || (ovr && !bus.ovr_clr);
      if (accept) begin
        dline[wr_ptr] <= bus.din;
        wr_ptr <= wr_ptr + PW'(1);
        phase <= !phase;
      end
      if (start) begin
        state <= ST_MAC;
        k <= '0;
      end else if (state == ST_MAC) begin
        k <= k + PW'(1);
        if (k == PW'(NTAP - 1)) state <= ST_RND;
      end else if (state == ST_RND) begin
        dout <= DOUT_W'(sat(64'(acc_rnd >>> SHIFT), DOUT_W));
        dout_vld <= 1'b1;
        state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: random and directed stimulus against a queue-based convolution model
module tb_cic_comp_fir;
  import cic_comp_pkg::*;
  localparam int NTAP = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  cic_comp_fir_if bus0 ();
  cic_comp_fir_if bus1 ();
  cic_comp_fir #(.SHIFT(17)) u0 (.clk(clk), .rstn(rstn), .bus(bus0));
  cic_comp_fir #(.SHIFT(18)) u1 (.clk(clk), .rstn(rstn), .bus(bus1));
  int checks = 0;
  int errors = 0;
  longint hist[$];
  longint obs[$];
  int busy_left, nacc;
  bit mvld, movr;
  longint md0, md1, p0, p1;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // direct convolution over the newest NTAP accepted samples, then round and clamp
  function automatic longint fir(input int s);
    longint acc, r;
    acc = 0;
    for (int i = 0; i < NTAP; i++) acc += longint'(COEF[i]) * hist[i];
    r = (acc + (64'sd1 <<< (s - 1))) >>> s;
    return r > 8388607 ? 64'sd8388607 : r < -8388608 ? -64'sd8388608 : r;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NTAP; i++) hist.push_back(0);
    busy_left = 0;
    nacc = 0;
    mvld = 0;
    movr = 0;
    md0 = 0;
    md1 = 0;
  endtask

  task automatic drive(input longint d, input bit v, input bit c);
    bus0.din = 35'(d);
    bus1.din = 35'(d);
    bus0.din_vld = v;
    bus1.din_vld = v;
    bus0.ovr_clr = c;
    bus1.ovr_clr = c;
  endtask

  // one clock: drive, let the edge happen, advance the model, check at the falling edge
  task automatic step(input longint d, input bit v, input bit c);
    bit was_busy;
    drive(d, v, c);
    @(posedge clk);
    was_busy = busy_left > 0;
    mvld = 0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        mvld = 1;
        md0 = p0;
        md1 = p1;
      end
    end
    movr = (v && was_busy) || (movr && !c);
    if (v && !was_busy) begin
      hist.push_front(d);
      void'(hist.pop_back());
      nacc++;
      if (nacc % 2 == 0) begin
        p0 = fir(17);
        p1 = fir(18);
        busy_left = NTAP + 1;
      end
    end
    @(negedge clk);
    chk("vld0", bus0.dout_vld, mvld);
    chk("vld1", bus1.dout_vld, mvld);
    chk("dout0", bus0.dout, md0);
    chk("dout1", bus1.dout, md1);
    chk("busy", bus0.busy, busy_left > 0);
    chk("ovr", bus0.ovr, movr);
    if (bus0.dout_vld) obs.push_back(bus0.dout);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic strobe(input longint d, input int gap);
    step(d, 1, 0);
    idle(gap - 1);
  endtask

  task automatic impulse_run();
    obs.delete();
    strobe(2 ** 17, 20);
    repeat (17) strobe(0, 20);
    idle(5);
    chk("imp_cnt", obs.size(), 9);
    for (int i = 0; i < 9 && i < obs.size(); i++)
      chk("imp_val", obs[i], i < 8 ? longint'(COEF[2 * i + 1]) : 0);
  endtask

  initial begin
    logic [34:0] r35;
    int gap;
    model_reset();
    drive(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_dout", bus0.dout, 0);
    chk("rst_vld", bus0.dout_vld, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_ovr", bus0.ovr, 0);
    rstn = 1'b1;
    impulse_run();
    repeat (20) strobe(1000, 20);
    chk("dc_val", bus0.dout, 1000);
    chk("dc_ovr", bus0.ovr, 0);
    repeat (32) strobe(2 ** 30, 20);
    chk("sat_hi", bus0.dout, 8388607);
    repeat (32) strobe(-(2 ** 30), 20);
    chk("sat_lo", bus0.dout, -8388608);
    repeat (32) strobe(3, 20);
    chk("rnd_pos", bus1.dout, 2);
    repeat (32) strobe(-3, 20);
    chk("rnd_neg", bus1.dout, -1);
    if (nacc % 2 != 0) strobe(1, 20);
    strobe(7, 20);
    step(11, 1, 0);
    idle(4);
    step(13, 1, 0);
    chk("drop_ovr", bus0.ovr, 1);
    chk("drop_ptr", u0.wr_ptr, nacc % NTAP);
    chk("drop_phase", u0.phase, nacc % 2);
    idle(2);
    step(17, 1, 1);
    chk("ovr_set_wins", bus0.ovr, 1);
    idle(20);
    step(0, 0, 1);
    chk("ovr_clr", bus0.ovr, 0);
    for (int n = 0; n < 400; n++) begin
      r35 = 35'({$urandom, $urandom});
      gap = $urandom_range(1, 24);
      step($urandom_range(0, 3) == 0 ? longint'($signed(r35)) : longint'($urandom_range(0, 2000)) - 1000,
           1, $urandom_range(0, 15) == 0);
      idle(gap - 1);
    end
    idle(25);
    if (nacc % 2 == 0) strobe(5, 20);
    step(9, 1, 0);
    idle(5);
    chk("mac_k5", u0.k, 5);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dout", bus0.dout, 0);
    chk("mid_rst_vld", bus0.dout_vld, 0);
    chk("mid_rst_busy", bus0.busy, 0);
    chk("mid_rst_ovr", bus0.ovr, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(25);
    impulse_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimate-by-2 CIC droop-compensation FIR that sits directly downstream of `adc_top`. It consumes the 35-bit signed CIC output and its one-cycle valid strobe, and stores samples in a circular delay line. On every second accepted sample it runs a time-multiplexed single-MAC convolution, then emits a rounded, saturated 24-bit sample with a one-cycle valid strobe for the readout path.

## Interface
- `DIN_W`, 35: input sample width, signed.
- `DOUT_W`, 24: output sample width, signed.
- `COEF_W`, 18: coefficient width, signed.
- `NTAP`, 16: tap count; power of two, at least 4.
- `SHIFT`, 17: accumulator right shift. Coefficients sum to 2^17, so the default gives unity DC gain.
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `din`, input, DIN_W: CIC output sample.
- `din_vld`, input, 1: one-cycle strobe that qualifies `din`.
- `ovr_clr`, input, 1: clears `ovr`.
- `dout`, output, DOUT_W: filtered, decimated sample.
- `dout_vld`, output, 1: one-cycle strobe that qualifies `dout`.
- `busy`, output, 1: high while in MAC or RND.
- `ovr`, output, 1: sticky overrun flag.

## Operation
- Reset clears all delay-line entries to 0, `wr_ptr`, `phase`, the accumulator and the tap counter. All outputs reset to 0.
- **Accept:** `din_vld` with `busy`=0 writes `din` to `buf[wr_ptr]`, increments `wr_ptr` mod NTAP and toggles `phase`.
  - If the accepted sample makes `phase` wrap from 1 to 0, the FSM starts a computation.
  - So the 2nd, 4th, 6th, … accepted samples trigger outputs.
- **Drop:** `din_vld` with `busy`=1 discards the sample. `buf`, `wr_ptr` and `phase` are unchanged, and `ovr` is set.
- **`ovr`:** sticky. It is cleared by `ovr_clr` or reset. If set and clear occur in the same cycle, set wins.
- **FSM states:** IDLE, MAC, RND.
  - IDLE → MAC on a triggering accept. The accumulator is cleared and the tap counter k=0.
  - MAC: `acc += COEF[k] * buf[(wr_ptr-1-k) mod NTAP]`, where k=0 is the newest sample. After k=NTAP-1 the FSM goes to RND.
  - RND: `r = (acc + 2^(SHIFT-1)) >>> SHIFT`, an arithmetic shift. `r` is saturated to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1] and registered into `dout`. `dout_vld` pulses, and the FSM returns to IDLE.
- **Widths:** product is DIN_W+COEF_W bits. The accumulator is DIN_W+COEF_W+log2(NTAP) bits (57 at defaults), so it never overflows. Saturation happens only at the output.
- `dout` holds its value between strobes.
- Reset asserted mid-MAC aborts the computation. No `dout_vld` is issued, and the delay line restarts from zeros.

## Timing
- Input strobe in cycle t (a triggering accept) → MAC in cycles t+1…t+NTAP → RND in cycle t+NTAP+1.
- `dout`/`dout_vld` are registered and visible in cycle t+NTAP+2. Latency is NTAP+2 cycles (18 at defaults).
- `busy` is high in cycles t+1…t+NTAP+1.
- A `din_vld` in t+NTAP+2 or later is accepted. A non-triggering accept during IDLE never blocks.
- Minimum input strobe spacing with no drops: NTAP+2 cycles. The CIC decimation ratio guarantees this in normal use.

## Structure
- Package `cic_comp_pkg` holds:
  - the `COEF` localparam array (NTAP × COEF_W, symmetric, sum exactly 2^17);
  - the FSM state enum `comp_state_e`;
  - the `sat()` width-reduction function.
- Natural sub-module: `comp_mac`. It is a registered multiply-accumulate with `clr`/`en` controls, so a DSP-mapped variant can be swapped in.
- The delay line is inferred as a register array in the top; a small RAM is acceptable with a one-cycle read and a matching pipeline adjustment.

## Test plan
- **Impulse:** after reset, `din`=2^17 once, then zeros, strobes every 20 cycles. Required: successive `dout` values are COEF[1], COEF[3], …, COEF[15], then 0.
- **DC:** constant `din`=1000 at 20-cycle spacing. Required: from the 8th output onward `dout`=1000 exactly, with `ovr`=0.
- **Saturation:** constant `din`=2^30. Required: `dout` settles at 8388607. With `din`=-2^30, `dout` settles at -8388608.
- **Overrun:**
  - Two strobes 5 cycles apart, the first triggering. Required: the second is dropped, `ovr`=1, and `wr_ptr`/`phase` are unchanged.
  - `ovr_clr` and a new drop in the same cycle. Required: `ovr` stays 1.
- **Reset mid-MAC:** assert `rstn`=0 at MAC cycle k=5. Required: all outputs go to 0 immediately and no `dout_vld` occurs. The next impulse test reproduces the first scenario's sequence exactly.
- **Rounding:** `SHIFT`=18 with `din` constant 3. Required: `dout` is 2, because 1.5 rounds half-up. With `din` constant -3, `dout` is -1.
